// File: rtl/bitmap_offset_pipe_pkg.sv
// Shared code constants and the code-to-byte-size decode for the bitmap offset pipe.
package bitmap_offset_pipe_pkg;

   localparam logic [1:0] CODE_NONE0 = 2'b00;
   localparam logic [1:0] CODE_NONE1 = 2'b01;
   localparam logic [1:0] CODE_UNIT  = 2'b10;
   localparam logic [1:0] CODE_DUAL  = 2'b11;

   function automatic int unsigned code_size(input logic [1:0] code, input int unsigned unit);
      case (code)
         CODE_UNIT: return unit;
         CODE_DUAL: return 2 * unit;
         default:   return 0;
      endcase
   endfunction

endpackage

// File: rtl/bitmap_prefix_sum.sv
// Inclusive prefix sum of per-lane sizes, Kogge-Stone tree of depth clog2(LANES).
module bitmap_prefix_sum #(
   parameter int unsigned LANES = 8,
   parameter int unsigned OFF_W = 11,
   localparam int unsigned PW   = OFF_W + $clog2(LANES)
) (
   input  logic [LANES*OFF_W-1:0] i_sizes,
   output logic [LANES*PW-1:0]    o_prefix
);

   localparam int unsigned LEVELS = $clog2(LANES);

   // Wide enough that no partial sum ever wraps
   logic [PW-1:0] w_lvl [LEVELS+1][LANES];

   for (genvar i = 0; i < LANES; i++) begin : g_leaf
      assign w_lvl[0][i] = PW'(i_sizes[i*OFF_W +: OFF_W]);
      assign o_prefix[i*PW +: PW] = w_lvl[LEVELS][i];
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         if (i >= (1 << l)) begin : g_add
            assign w_lvl[l+1][i] = w_lvl[l][i] + w_lvl[l][i-(1<<l)];
         end else begin : g_pass
            assign w_lvl[l+1][i] = w_lvl[l][i];
         end
      end
   end

endmodule

// File: rtl/bitmap_offset_pipe.sv
// Two-stage pipe turning per-lane 2-bit size codes into running inclusive byte offsets.
module bitmap_offset_pipe
   import bitmap_offset_pipe_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned OFF_W = 11,
   parameter int unsigned UNIT  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*LANES-1:0]     in_bitmap,
   input  logic                   in_first,
   input  logic [OFF_W-1:0]       in_base,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OFF_W-1:0] out_offset,
   output logic [OFF_W-1:0]       out_total,
   output logic                   out_ovf
);

   localparam int unsigned PW = OFF_W + $clog2(LANES);

   logic                   r_s1_valid;
   logic                   r_s2_valid;
   logic [LANES*OFF_W-1:0] r_s1_sizes;
   logic [OFF_W-1:0]       r_s1_base;
   logic [OFF_W-1:0]       r_run_base;

   logic [LANES*OFF_W-1:0] w_sizes;
   logic [PW-1:0]          w_in_total;
   logic [OFF_W-1:0]       w_block_base;
   logic [LANES*PW-1:0]    w_prefix;
   logic [LANES*OFF_W-1:0] w_offsets;
   logic [OFF_W-1:0]       w_total;
   logic                   w_ovf;
   logic                   w_s2_adv;
   logic                   w_s1_adv;
   logic                   w_in_xfer;

   assign w_s2_adv     = !r_s2_valid || out_ready;
   assign w_s1_adv     = r_s1_valid && w_s2_adv;
   assign in_ready     = rst_n && (!r_s1_valid || w_s2_adv);
   assign w_in_xfer    = in_valid && in_ready;
   assign out_valid    = r_s2_valid;
   assign w_block_base = in_first ? in_base : r_run_base;

   // Decode at the input; the beat total is needed right away for the running base
   always_comb begin
      w_sizes    = '0;
      w_in_total = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sizes[i*OFF_W +: OFF_W] = OFF_W'(code_size(in_bitmap[2*i +: 2], UNIT));
         w_in_total = w_in_total + PW'(w_sizes[i*OFF_W +: OFF_W]);
      end
   end

   bitmap_prefix_sum #(
      .LANES (LANES),
      .OFF_W (OFF_W)
   ) u_prefix (
      .i_sizes  (r_s1_sizes),
      .o_prefix (w_prefix)
   );

   // Offsets are monotonic, so any lane wrapping implies the last lane wrapped
   always_comb begin
      logic [PW:0] w_full;
      w_offsets = '0;
      w_ovf     = 1'b0;
      w_full    = '0;
      for (int i = 0; i < LANES; i++) begin
         w_full = (PW+1)'(r_s1_base) + (PW+1)'(w_prefix[i*PW +: PW]);
         w_offsets[i*OFF_W +: OFF_W] = w_full[OFF_W-1:0];
         w_ovf = w_ovf | (w_full[PW:OFF_W] != '0);
      end
      w_total = w_prefix[(LANES-1)*PW +: OFF_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_sizes <= '0;
         r_s1_base  <= '0;
         r_run_base <= '0;
         out_offset <= '0;
         out_total  <= '0;
         out_ovf    <= 1'b0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_xfer) begin
            r_s1_sizes <= w_sizes;
            r_s1_base  <= w_block_base;
            r_run_base <= OFF_W'(w_block_base + w_in_total);
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s1_adv) begin
            out_offset <= w_offsets;
            out_total  <= w_total;
            out_ovf    <= w_ovf;
         end
      end
   end

endmodule

// File: tb/tb_bitmap_offset_pipe.sv
// Scoreboard bench for bitmap_offset_pipe: directed vectors, stalls, reset flush and random traffic.
module tb_bitmap_offset_pipe;

   localparam int unsigned LANES = 8;
   localparam int unsigned OFF_W = 11;
   localparam int unsigned UNIT  = 16;
   localparam int          MODV  = 1 << OFF_W;

   typedef struct {
      logic [LANES*OFF_W-1:0] off;
      logic [OFF_W-1:0]       total;
      logic                   ovf;
   } exp_t;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [2*LANES-1:0]     in_bitmap;
   logic                   in_first;
   logic [OFF_W-1:0]       in_base;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*OFF_W-1:0] out_offset;
   logic [OFF_W-1:0]       out_total;
   logic                   out_ovf;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   run_base = 0;
   int   ready_mode = 1;        // 0 never, 1 always, 2 random
   logic last_in_ready;

   bitmap_offset_pipe #(.LANES(LANES), .OFF_W(OFF_W), .UNIT(UNIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bitmap  (in_bitmap),
      .in_first   (in_first),
      .in_base    (in_base),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_offset (out_offset),
      .out_total  (out_total),
      .out_ovf    (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: walk the lanes serially with unbounded integers, wrap only at the end
   task automatic predict(input logic [2*LANES-1:0] bm, input logic first, input int base);
      exp_t       e;
      int         bb;
      int         acc;
      int         tot;
      int         sz;
      logic [1:0] c;
      bb  = first ? base : run_base;
      acc = bb;
      tot = 0;
      e.off = '0;
      for (int i = 0; i < LANES; i++) begin
         c  = bm[2*i +: 2];
         sz = (c == 2'b10) ? UNIT : (c == 2'b11) ? 2 * UNIT : 0;
         acc += sz;
         tot += sz;
         e.off[i*OFF_W +: OFF_W] = OFF_W'(acc % MODV);
      end
      e.total  = OFF_W'(tot % MODV);
      e.ovf    = (acc >= MODV);
      run_base = (bb + tot) % MODV;
      sb.push_back(e);
   endtask

   function automatic logic pick_ready();
      if (ready_mode == 0) return 1'b0;
      if (ready_mode == 1) return 1'b1;
      return ($urandom_range(3) != 0);
   endfunction

   // One clock: drive after the edge, decide acceptance at the falling edge
   task automatic cycle(input logic v, input logic [2*LANES-1:0] bm, input logic f,
                        input int base, input logic ordy, output logic acc);
      in_valid  = v;
      in_bitmap = bm;
      in_first  = f;
      in_base   = OFF_W'(base);
      out_ready = ordy;
      @(negedge clk);
      last_in_ready = in_ready;
      acc = v && in_ready;
      if (acc) predict(bm, f, base);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2*LANES-1:0] bm, input logic f, input int base);
      logic a;
      int   n;
      n = 0;
      a = 1'b0;
      while (!a && n < 100) begin
         cycle(1'b1, bm, f, base, pick_ready(), a);
         n++;
      end
      if (!a) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted");
      end
   endtask

   // Idle cycles carry in_first=1 and a junk base, which must be ignored
   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 16'($urandom), 1'b1, int'($urandom_range(MODV - 1)), pick_ready(), a);
      end
   endtask

   // Monitor: pop and compare on every output transfer, check hold stability during stalls
   logic                   hold;
   logic [LANES*OFF_W-1:0] h_off;
   logic [OFF_W-1:0]       h_total;
   logic                   h_ovf;
   exp_t                   m_e;

   initial hold = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else if (out_valid) begin
         if (hold) begin
            chk("hold_offset", 128'(out_offset), 128'(h_off));
            chk("hold_total",  128'(out_total),  128'(h_total));
            chk("hold_ovf",    128'(out_ovf),    128'(h_ovf));
         end
         if (out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=out_valid required=no_beat");
            end else begin
               m_e = sb.pop_front();
               chk("offset", 128'(out_offset), 128'(m_e.off));
               chk("total",  128'(out_total),  128'(m_e.total));
               chk("ovf",    128'(out_ovf),    128'(m_e.ovf));
            end
            hold = 1'b0;
         end else begin
            hold    = 1'b1;
            h_off   = out_offset;
            h_total = out_total;
            h_ovf   = out_ovf;
         end
      end else begin
         if (hold) begin
            checks++;
            failures++;
            $display("FAIL valid_dropped actual=0 required=1");
         end
         hold = 1'b0;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      ready_mode = 1;
      while (sb.size() != 0 && n < 50) begin
         idle(1);
         n++;
      end
      idle(3);
      chk("drain_empty", 128'(sb.size()), 128'(0));
   endtask

   logic [2*LANES-1:0] burst [6];
   logic               a;
   int                 sent;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bitmap = '0;
      in_first  = 1'b0;
      in_base   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_in_ready",   128'(in_ready),   128'(0));
      chk("reset_out_valid",  128'(out_valid),  128'(0));
      chk("reset_out_offset", 128'(out_offset), 128'(0));
      chk("reset_out_total",  128'(out_total),  128'(0));
      chk("reset_out_ovf",    128'(out_ovf),    128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vectors
      ready_mode = 1;
      send(16'hFFFF, 1'b1, 0);
      send(16'hAAAA, 1'b0, 0);
      idle(4);
      send(16'h0003, 1'b1, 2000);
      send(16'h000F, 1'b0, 0);
      send(16'h5555, 1'b1, 100);
      send(16'h0000, 1'b0, 0);
      drain();

      // Back-to-back burst with a three-cycle downstream stall
      for (int i = 0; i < 6; i++) burst[i] = 16'($urandom);
      sent = 0;
      for (int c = 0; c < 40 && sent < 6; c++) begin
         cycle(1'b1, burst[sent], (sent == 0), 321, !(c >= 3 && c <= 5), a);
         if (c == 5) chk("stall_in_ready", 128'(last_in_ready), 128'(0));
         if (a) sent++;
      end
      chk("burst_sent", 128'(sent), 128'(6));
      drain();

      // Random traffic with random backpressure
      ready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) != 0) begin
            send(16'($urandom), ($urandom_range(3) == 0), int'($urandom_range(MODV - 1)));
         end else begin
            idle(1);
         end
      end
      drain();

      // Reset with two beats in flight
      ready_mode = 0;
      send(16'hFFFF, 1'b1, 5);
      send(16'h00FF, 1'b0, 0);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midreset_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("midreset_out_valid",  128'(out_valid),  128'(0));
      chk("midreset_out_offset", 128'(out_offset), 128'(0));
      chk("midreset_out_total",  128'(out_total),  128'(0));
      sb.delete();
      run_base = 0;
      rst_n = 1'b1;
      ready_mode = 1;
      send(16'h0002, 1'b0, 0);
      chk("post_reset_in_ready", 128'(last_in_ready), 128'(1));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
